// File: rtl/branch_resolver_pkg.sv
// Shared constants for the branch resolver: op kinds, branch funct3 codes,
// default widths and the branch-condition helper.
package branch_resolver_pkg;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned TAG_W_DEF      = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned PC_W_DEF       = 17;

  // Control-flow op kind as issued by the RS
  typedef enum logic [1:0] {
    KIND_BRANCH = 2'd0,
    KIND_JAL    = 2'd1,
    KIND_JALR   = 2'd2,
    KIND_RSVD   = 2'd3
  } kind_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Branch condition from precomputed compare results; undefined codes are not-taken
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic       eq,
                                        input logic       lt_s,
                                        input logic       lt_u);
    logic t;
    t = 1'b0;
    case (funct3)
      F3_BEQ:  t = eq;
      F3_BNE:  t = !eq;
      F3_BLT:  t = lt_s;
      F3_BGE:  t = !lt_s;
      F3_BLTU: t = lt_u;
      F3_BGEU: t = !lt_u;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_resolver_fifo.sv
// resolver_fifo: synchronous FIFO of resolved results.
// Ports: clk, rst (async active-low), en (global freeze when low), clr (flush),
// push/din, pop/dout (head), count (occupancy). DEPTH must be a power of two.
module resolver_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointer/count update; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (en && !clr && push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: resolves branch/JAL/JALR ops from the RS, trains the
// predictor and queues results for CDB write-back.
// Ports: clk, rst (async active-low), rdy (freeze), clr (flush);
// in_* op from RS with in_valid/in_ready; train_* predictor training pulse;
// out_* FIFO head toward the ROB, popped by cdb_grant.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned TAG_W      = TAG_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned PC_W       = PC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_kind,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             in_pred_taken,
  input  logic [TAG_W-1:0] in_tag,
  output logic             train_ready,
  output logic             train_result,
  output logic [XLEN-1:0]  train_pc,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_value,
  output logic             out_mispredict,
  output logic [XLEN-1:0]  out_target,
  input  logic             cdb_grant
);

  localparam int unsigned ENT_W = TAG_W + 2 * XLEN + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_MASK = XLEN'((64'd1 << PC_W) - 64'd1);

  // Stage register S1
  logic             s1_valid;
  kind_e            s1_kind;
  logic [2:0]       s1_funct3;
  logic [XLEN-1:0]  s1_rs1;
  logic [XLEN-1:0]  s1_rs2;
  logic [XLEN-1:0]  s1_imm;
  logic [XLEN-1:0]  s1_pc;
  logic             s1_pred;
  logic [TAG_W-1:0] s1_tag;

  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] occupancy;
  logic             accept;

  // S1 always holds a reserved FIFO slot, so it counts against capacity
  assign occupancy = fifo_count + CNT_W'(s1_valid);
  assign in_ready  = !clr && (occupancy < CNT_W'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready && rdy;

  // S1 load; an occupied S1 always drains into the FIFO on the next rdy edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_kind   <= KIND_BRANCH;
      s1_funct3 <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_imm    <= '0;
      s1_pc     <= '0;
      s1_pred   <= 1'b0;
      s1_tag    <= '0;
    end else if (rdy) begin
      if (clr) begin
        s1_valid <= 1'b0;
      end else begin
        s1_valid <= accept;
        if (accept) begin
          s1_kind   <= kind_e'(in_kind);
          s1_funct3 <= in_funct3;
          s1_rs1    <= in_rs1;
          s1_rs2    <= in_rs2;
          s1_imm    <= in_imm;
          s1_pc     <= in_pc;
          s1_pred   <= in_pred_taken;
          s1_tag    <= in_tag;
        end
      end
    end
  end

  // Resolution of the op held in S1
  logic            taken;
  logic            mispredict;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] link_value;
  logic [XLEN-1:0] target;
  logic            cmp_eq;
  logic            cmp_lt_s;
  logic            cmp_lt_u;

  assign cmp_eq   = (s1_rs1 == s1_rs2);
  assign cmp_lt_s = ($signed(s1_rs1) < $signed(s1_rs2));
  assign cmp_lt_u = (s1_rs1 < s1_rs2);

  always_comb begin
    taken      = 1'b0;
    mispredict = 1'b0;
    raw_target = s1_pc + XLEN'(4);
    link_value = '0;
    case (s1_kind)
      KIND_BRANCH: begin
        taken      = branch_taken(s1_funct3, cmp_eq, cmp_lt_s, cmp_lt_u);
        raw_target = taken ? (s1_pc + s1_imm) : (s1_pc + XLEN'(4));
        mispredict = (taken != s1_pred);
      end
      KIND_JAL: begin
        taken      = 1'b1;
        raw_target = s1_pc + s1_imm;
        link_value = s1_pc + XLEN'(4);
        mispredict = !s1_pred;
      end
      KIND_JALR: begin
        taken      = 1'b1;
        raw_target = (s1_rs1 + s1_imm) & ~XLEN'(1);
        link_value = s1_pc + XLEN'(4);
        mispredict = 1'b1;
      end
      default: begin
        // Reserved kind behaves as a not-taken branch
        taken      = 1'b0;
        raw_target = s1_pc + XLEN'(4);
        mispredict = s1_pred;
      end
    endcase
  end

  assign target = raw_target & PC_MASK;

  // Training pulse: conditional branches only, suppressed while frozen or flushing
  assign train_ready  = s1_valid && (s1_kind == KIND_BRANCH) && rdy && !clr;
  assign train_result = train_ready && taken;
  assign train_pc     = train_ready ? s1_pc : '0;

  // Result queue
  logic [ENT_W-1:0] fifo_din;
  logic [ENT_W-1:0] fifo_dout;
  logic [TAG_W-1:0] head_tag;
  logic [XLEN-1:0]  head_value;
  logic             head_mis;
  logic [XLEN-1:0]  head_target;

  assign fifo_din = {s1_tag, link_value, mispredict, target};

  resolver_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .en    (rdy),
    .clr   (clr),
    .push  (s1_valid),
    .pop   (out_valid && cdb_grant),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign {head_tag, head_value, head_mis, head_target} = fifo_dout;

  // Head presentation; zero when empty so stale storage never leaks out
  assign out_valid      = (fifo_count != '0);
  assign out_tag        = out_valid ? head_tag    : '0;
  assign out_value      = out_valid ? head_value  : '0;
  assign out_mispredict = out_valid && head_mis;
  assign out_target     = out_valid ? head_target : '0;

endmodule
